// File: rtl/fetch_decode_fifo_pkg.sv
// Shared fetch/decode configuration: widths, FIFO depth and the fetch->decode payload.
// Also holds a small mask helper used by the FIFO's protocol checks.
package fetch_decode_fifo_pkg;

  localparam int unsigned FETCH_WIDTH            = 4;
  localparam int unsigned DECODE_WIDTH           = 2;
  localparam int unsigned FETCH_DECODE_FIFO_SIZE = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] value;
    logic        has_exception;
  } fetch_decode_pack_t;

  // True when the set bits of m form a contiguous run starting at bit 0.
  function automatic logic is_prefix_mask(input logic [31:0] m);
    return (m & (m + 32'd1)) == '0;
  endfunction

endpackage

// File: rtl/fetch_decode_fifo_popcount_prefix.sv
// popcount_prefix: number of contiguous ones in bits_i counted upward from bit 0.
module popcount_prefix #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [CW-1:0]    count_o
);

  logic run;

  always_comb begin
    count_o = '0;
    run     = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      run = run & bits_i[i];
      if (run) count_o = count_o + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_decode_fifo.sv
// Multi-ported in-order fetch->decode FIFO with prefix push/pop and flush.
// Define FETCH_DECODE_FIFO_PERF_EN to add the full/empty cycle counters.
module fetch_decode_fifo
  import fetch_decode_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = FETCH_DECODE_FIFO_SIZE,
  parameter int unsigned PUSH_WIDTH = FETCH_WIDTH,
  parameter int unsigned POP_WIDTH  = DECODE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  fetch_decode_pack_t [PUSH_WIDTH-1:0]  data_in,
  input  logic [PUSH_WIDTH-1:0]                data_in_valid,
  input  logic                                 push,
  output logic [PUSH_WIDTH-1:0]                data_in_space,
  output fetch_decode_pack_t [POP_WIDTH-1:0]   data_out,
  output logic [POP_WIDTH-1:0]                 data_out_valid,
  input  logic [POP_WIDTH-1:0]                 data_pop_valid,
  input  logic                                 pop,
  input  logic                                 flush,
  output logic                                 full,
  output logic                                 empty
`ifdef FETCH_DECODE_FIFO_PERF_EN
  ,
  output logic [63:0]                          perf_full_cycles,
  output logic [63:0]                          perf_empty_cycles
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned PCW = $clog2(PUSH_WIDTH + 1);
  localparam int unsigned QCW = $clog2(POP_WIDTH + 1);

  fetch_decode_pack_t mem_q [DEPTH];

  logic [PW-1:0]  rptr_q, rptr_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  count;
  logic [PW-1:0]  free_cnt;
  logic [PCW-1:0] push_run, push_cnt;
  logic [QCW-1:0] pop_run, pop_cnt;

  // Pointers carry a wrap bit, so plain subtraction yields 0..DEPTH.
  assign count    = wptr_q - rptr_q;
  assign free_cnt = PW'(DEPTH) - count;
  assign full     = (count == PW'(DEPTH));
  assign empty    = (count == '0);

  always_comb begin
    data_in_space = '0;
    for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
      data_in_space[i] = (free_cnt > PW'(i));
    end
  end

  always_comb begin
    data_out_valid = '0;
    data_out       = '0;
    for (int unsigned i = 0; i < POP_WIDTH; i++) begin
      data_out_valid[i] = (count > PW'(i));
      data_out[i]       = mem_q[AW'(rptr_q + PW'(i))];
    end
  end

  popcount_prefix #(.WIDTH(PUSH_WIDTH)) u_push_cnt (
    .bits_i  (data_in_valid & data_in_space),
    .count_o (push_run)
  );

  popcount_prefix #(.WIDTH(POP_WIDTH)) u_pop_cnt (
    .bits_i  (data_pop_valid & data_out_valid),
    .count_o (pop_run)
  );

  // Flush suppresses both strobes so storage and pointers see no traffic.
  assign push_cnt = (push && !flush) ? push_run : '0;
  assign pop_cnt  = (pop  && !flush) ? pop_run  : '0;

  always_comb begin
    rptr_d = rptr_q + PW'(pop_cnt);
    wptr_d = wptr_q + PW'(push_cnt);
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
      if (PCW'(i) < push_cnt) begin
        mem_q[AW'(wptr_q + PW'(i))] <= data_in[i];
      end
    end
  end

`ifdef FETCH_DECODE_FIFO_PERF_EN
  logic [63:0] perf_full_q, perf_empty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_full_q  <= perf_full_q + 64'(full);
      perf_empty_q <= perf_empty_q + 64'(empty);
    end
  end

  assign perf_full_cycles  = perf_full_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (is_prefix_mask(32'(data_in_valid)));
      assert (is_prefix_mask(32'(data_pop_valid)));
      assert (count <= PW'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_fifo.sv
// Randomized + directed bench for fetch_decode_fifo against a queue-based reference model.
module tb_fetch_decode_fifo;
  import fetch_decode_fifo_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PWN   = 4;
  localparam int unsigned QWN   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_decode_pack_t [PWN-1:0] data_in;
  logic [PWN-1:0] data_in_valid, data_in_space;
  logic push, pop, flush, full, empty;
  fetch_decode_pack_t [QWN-1:0] data_out;
  logic [QWN-1:0] data_out_valid, data_pop_valid;
`ifdef FETCH_DECODE_FIFO_PERF_EN
  logic [63:0] perf_full_cycles, perf_empty_cycles;
`endif

  fetch_decode_fifo #(.DEPTH(DEPTH), .PUSH_WIDTH(PWN), .POP_WIDTH(QWN)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .push           (push),
    .data_in_space  (data_in_space),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_pop_valid (data_pop_valid),
    .pop            (pop),
    .flush          (flush),
    .full           (full),
    .empty          (empty)
`ifdef FETCH_DECODE_FIFO_PERF_EN
    ,
    .perf_full_cycles  (perf_full_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  fetch_decode_pack_t model_q[$];
  longint unsigned m_full_cyc = 0;
  longint unsigned m_empty_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on each clock edge using the inputs held across it.
  task automatic model_step();
    int n, np, npop;
    if (rst) begin
      model_q.delete();
      m_full_cyc  = 0;
      m_empty_cyc = 0;
      return;
    end
    n = model_q.size();
    if (n == DEPTH) m_full_cyc++;
    if (n == 0) m_empty_cyc++;
    if (flush) begin
      model_q.delete();
      return;
    end
    np = push ? $countones(data_in_valid) : 0;
    if (np > DEPTH - n) np = DEPTH - n;
    npop = pop ? $countones(data_pop_valid) : 0;
    if (npop > n) npop = n;
    repeat (npop) void'(model_q.pop_front());
    for (int i = 0; i < np; i++) model_q.push_back(data_in[i]);
  endtask

  always @(negedge clk) begin
    int n;
    if (checking) begin
      n = model_q.size();
      chk("empty", 64'(empty), 64'(n == 0));
      chk("full", 64'(full), 64'(n == DEPTH));
      for (int i = 0; i < PWN; i++)
        chk("data_in_space", 64'(data_in_space[i]), 64'((DEPTH - n) > i));
      for (int i = 0; i < QWN; i++) begin
        chk("data_out_valid", 64'(data_out_valid[i]), 64'(n > i));
        if (n > i) begin
          chk("data_out.pc", 64'(data_out[i].pc), 64'(model_q[i].pc));
          chk("data_out.value", 64'(data_out[i].value), 64'(model_q[i].value));
          chk("data_out.exc", 64'(data_out[i].has_exception), 64'(model_q[i].has_exception));
        end
      end
`ifdef FETCH_DECODE_FIFO_PERF_EN
      chk("perf_full_cycles", perf_full_cycles, m_full_cyc);
      chk("perf_empty_cycles", perf_empty_cycles, m_empty_cyc);
`endif
    end
  end

  task automatic drive(input logic p, input logic [3:0] vm, input logic [31:0] pcb,
                       input logic q, input logic [1:0] pm, input logic f);
    push = p; data_in_valid = vm; pop = q; data_pop_valid = pm; flush = f;
    for (int i = 0; i < PWN; i++) begin
      data_in[i].pc            = pcb + 32'(4 * i);
      data_in[i].value         = $urandom();
      data_in[i].has_exception = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic p, input logic [3:0] vm, input logic [31:0] pcb,
                     input logic q, input logic [1:0] pm, input logic f);
    drive(p, vm, pcb, q, pm, f);
    tick();
    drive(1'b0, 4'b0, 32'h0, 1'b0, 2'b0, 1'b0);
  endtask

  initial begin
    int nv, np;
    drive(1'b0, 4'b0, 32'h0, 1'b0, 2'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_q.delete();
    m_full_cyc = 0; m_empty_cyc = 0;
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_dov", 64'(data_out_valid), 64'h0);
    chk("reset_space", 64'(data_in_space), 64'hF);
    checking = 1'b1;

    cyc(1'b1, 4'hF, 32'h8000_0000, 1'b0, 2'b00, 1'b0);
    chk("s1_dov", 64'(data_out_valid), 64'h3);
    chk("s1_pc0", 64'(data_out[0].pc), 64'h8000_0000);
    chk("s1_pc1", 64'(data_out[1].pc), 64'h8000_0004);
    chk("s1_space", 64'(data_in_space), 64'hF);
    chk("s1_empty", 64'(empty), 64'd0);

    cyc(1'b0, 4'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 4'hF, 32'h200, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 4'hF, 32'h210, 1'b0, 2'b00, 1'b0);
    chk("s2_full", 64'(full), 64'd1);
    chk("s2_space", 64'(data_in_space), 64'h0);
    cyc(1'b1, 4'hF, 32'h300, 1'b0, 2'b00, 1'b0);
    chk("s2_full_hold", 64'(full), 64'd1);
    chk("s2_head_pc", 64'(data_out[0].pc), 64'h200);

    cyc(1'b1, 4'hF, 32'h400, 1'b1, 2'b11, 1'b0);
    chk("s3_full", 64'(full), 64'd0);
    chk("s3_space", 64'(data_in_space), 64'h3);
    chk("s3_pc0", 64'(data_out[0].pc), 64'h208);
    chk("s3_pc1", 64'(data_out[1].pc), 64'h20C);

    cyc(1'b0, 4'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 4'hF, 32'h500, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 4'h3, 32'h600, 1'b0, 2'b00, 1'b0);
    repeat (3) cyc(1'b0, 4'h0, 32'h0, 1'b1, 2'b11, 1'b0);
    chk("s4_empty", 64'(empty), 64'd1);
    cyc(1'b1, 4'hF, 32'h100, 1'b0, 2'b00, 1'b0);
    chk("s4_pc0", 64'(data_out[0].pc), 64'h100);
    chk("s4_pc1", 64'(data_out[1].pc), 64'h104);
    cyc(1'b0, 4'h0, 32'h0, 1'b1, 2'b11, 1'b0);
    chk("s4_pc2", 64'(data_out[0].pc), 64'h108);
    chk("s4_pc3", 64'(data_out[1].pc), 64'h10C);
    cyc(1'b0, 4'h0, 32'h0, 1'b1, 2'b11, 1'b0);
    chk("s4_drained", 64'(empty), 64'd1);

    cyc(1'b1, 4'hF, 32'h700, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 4'h1, 32'h710, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 4'hF, 32'h720, 1'b1, 2'b11, 1'b1);
    chk("s5_empty", 64'(empty), 64'd1);
    chk("s5_dov", 64'(data_out_valid), 64'h0);
    chk("s5_space", 64'(data_in_space), 64'hF);

    cyc(1'b1, 4'h7, 32'h800, 1'b0, 2'b00, 1'b0);
    #2 rst = 1'b1;
    model_q.delete();
    m_full_cyc = 0; m_empty_cyc = 0;
    #1;
    chk("s6_empty", 64'(empty), 64'd1);
    chk("s6_full", 64'(full), 64'd0);
    chk("s6_dov", 64'(data_out_valid), 64'h0);
    chk("s6_space", 64'(data_in_space), 64'hF);
`ifdef FETCH_DECODE_FIFO_PERF_EN
    chk("s6_perf_full", perf_full_cycles, 64'd0);
`endif
    tick();
    rst = 1'b0;
    repeat (3) tick();
`ifdef FETCH_DECODE_FIFO_PERF_EN
    chk("s6_perf_empty", perf_empty_cycles, 64'd3);
`endif

    for (int k = 0; k < 3000; k++) begin
      nv = $urandom_range(0, PWN);
      np = $urandom_range(0, QWN);
      drive($urandom_range(0, 3) != 0, 4'((1 << nv) - 1), $urandom(),
            $urandom_range(0, 2) != 0, 2'((1 << np) - 1), $urandom_range(0, 31) == 0);
      tick();
    end

    drive(1'b0, 4'b0, 32'h0, 1'b0, 2'b0, 1'b0);
    @(negedge clk);
    #1 checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
